// File: rtl/arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx_if.sv
// Handshake bundle between a word source, the req/ack transmitter and the remote receiver.
interface arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx_if #(
    parameter int DATA_W = 124
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              xfer_req;
    logic [DATA_W-1:0] xfer_data;
    logic              xfer_ack;

    modport master (
        output in_valid, in_data, xfer_ack,
        input  in_ready, xfer_req, xfer_data
    );

    modport slave (
        input  in_valid, in_data, xfer_ack,
        output in_ready, xfer_req, xfer_data
    );
endinterface

// File: rtl/arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx.sv
// Transmit side of a four-phase req/ack level handshake carrying one word per transfer.
// state | meaning: IDLE = waiting for a word, REQ = req high awaiting ack, REL = req low awaiting ack release
module arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx #(
    parameter int DATA_W      = 124,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx_if.slave bus,
    output logic                                     done,
    output logic                                     busy,
    output logic                                     timeout_err,
    output logic [CNT_W-1:0]                         xfer_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;

    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [TO_W-1:0]        to_cnt;
    logic                   req_q;
    logic [DATA_W-1:0]      data_q;
    logic                   in_ready;
    logic                   accept;

    assign ack_s         = ack_sync[SYNC_STAGES-1];
    // A stale ack still high from the remote side must block the next word.
    assign in_ready      = (state == IDLE) && !ack_s;
    assign accept        = bus.in_valid && in_ready;
    assign done          = (state == REL) && !ack_s;
    assign busy          = (state != IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.xfer_req  = req_q;
    assign bus.xfer_data = data_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (ack_s)  state_next = REL;
            REL:     if (!ack_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync    <= '0;
            state       <= IDLE;
            req_q       <= 1'b0;
            data_q      <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            xfer_count  <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.xfer_ack};
            state    <= state_next;
            req_q    <= (state_next == REQ);
            if (accept) begin
                data_q <= bus.in_data;
            end
            if (done) begin
                xfer_count <= xfer_count + 1'b1;
            end
            // Stall watchdog only reports; the phase is never abandoned.
            if (state_next != state) begin
                to_cnt <= '0;
            end else if (busy && (to_cnt != TO_MAX)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((TIMEOUT_CYC != 0) && (to_cnt == TO_MAX)) begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx.sv
// Self-checking bench for the req/ack transmitter with a modelled remote receiver.
module tb_arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx;
    localparam int DATA_W = 124;
    localparam int CNT_W  = 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  exp_count;
    } vec_t;

    logic clk;
    logic rst;
    logic done;
    logic busy;
    logic timeout_err;
    logic [CNT_W-1:0] xfer_count;

    arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx_if #(.DATA_W(DATA_W)) bus ();

    arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(10),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .done(done),
        .busy(busy),
        .timeout_err(timeout_err),
        .xfer_count(xfer_count)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic remote_en;
    logic forced_ack;
    logic seen_req;
    logic [DATA_W-1:0] sb[$];
    vec_t vecs[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remote receiver: echoes req one cycle later unless overridden.
    initial begin
        bus.xfer_ack = 1'b0;
        forever begin
            @(negedge clk);
            seen_req = bus.xfer_req;
            @(posedge clk);
            #2;
            bus.xfer_ack = remote_en ? seen_req : forced_ack;
        end
    end

    // Scoreboard on done pulses, plus frozen-data check while busy.
    logic prev_busy = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 128'(1), 128'(0));
            end else begin
                chk("done_data", 128'(bus.xfer_data), 128'(sb.pop_front()));
            end
        end
        if (prev_busy && busy && !rst) begin
            chk("data_frozen", 128'(bus.xfer_data), 128'(prev_data));
        end
        prev_busy = busy;
        prev_data = bus.xfer_data;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sb.delete();
    endtask

    // Hold a word valid until accepted; returns one cycle after the accept edge.
    task automatic send(input logic [DATA_W-1:0] word);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        next_cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = {4{31'h5A5A_1234}};
        chk("send_accept", 128'(n < 100), 128'(1));
        if (n < 100) sb.push_back(word);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 128'(done_cnt >= target), 128'(1));
        next_cycle();
    endtask

    initial begin
        int base;
        int idx;
        int n;
        logic acc;

        vecs[0] = '{124'h0000_1111, 2'd1};
        vecs[1] = '{124'hDEAD_BEEF_0000_0001, 2'd2};
        vecs[2] = '{{4{31'h7FFF_FFFF}}, 2'd3};
        vecs[3] = '{124'h8000_0000_0000_0000_0000_0000_0000_000, 2'd0};
        vecs[4] = '{124'h0C0F_FEE0, 2'd1};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        remote_en    = 1'b1;
        forced_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_req", 128'(bus.xfer_req), 128'(0));
        chk("rst_data", 128'(bus.xfer_data), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_count", 128'(xfer_count), 128'(0));
        chk("rst_err", 128'(timeout_err), 128'(0));
        chk("rst_ready", 128'(bus.in_ready), 128'(1));
        next_cycle();

        // Single transfer with exact phase timing.
        bus.in_valid = 1'b1;
        bus.in_data  = 124'h0ABC;
        sb.push_back(124'h0ABC);
        next_cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = 124'h0FFF_FFFF;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("single_req_c%0d", c), 128'(bus.xfer_req), 128'(c <= 4));
            chk($sformatf("single_done_c%0d", c), 128'(done), 128'(c == 8));
            chk($sformatf("single_ready_c%0d", c), 128'(bus.in_ready), 128'(c == 9));
            if (c <= 8) chk($sformatf("single_data_c%0d", c), 128'(bus.xfer_data), 128'(124'h0ABC));
            if (c == 9) chk("single_count", 128'(xfer_count), 128'(1));
            next_cycle();
        end

        // Back-to-back with in_valid held high.
        do_reset();
        base = done_cnt;
        idx = 0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 124'd1;
        while (idx < 3 && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) chk("b2b_accept_idle", 128'(busy), 128'(0));
            next_cycle();
            if (acc) begin
                sb.push_back(DATA_W'(idx + 1));
                idx++;
                if (idx < 3) bus.in_data = DATA_W'(idx + 1);
                else bus.in_valid = 1'b0;
            end
            n++;
        end
        chk("b2b_accepts", 128'(idx), 128'(3));
        wait_dones(base + 3, 100);
        repeat (10) next_cycle();
        @(negedge clk);
        chk("b2b_done_pulses", 128'(done_cnt - base), 128'(3));
        chk("b2b_count", 128'(xfer_count), 128'(3));
        next_cycle();

        // Stale ack while idle blocks accepts.
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin remote_en = 1'b0; forced_ack = 1'b1; end
            if (c == 2) begin bus.in_valid = 1'b1; bus.in_data = 124'h55; end
            if (c == 6) forced_ack = 1'b0;
            if (c == 7) bus.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("stale_ready_c%0d", c), 128'(bus.in_ready), 128'((c < 2) || (c >= 8)));
            chk($sformatf("stale_busy_c%0d", c), 128'(busy), 128'(0));
            next_cycle();
        end
        remote_en = 1'b1;
        repeat (3) next_cycle();

        // Table-driven transfers covering the count wrap.
        do_reset();
        base = done_cnt;
        foreach (vecs[i]) begin
            send(vecs[i].data);
            wait_dones(base + i + 1, 60);
            @(negedge clk);
            chk($sformatf("wrap_count_%0d", i), 128'(xfer_count), 128'(vecs[i].exp_count));
            next_cycle();
        end

        // Timeout with a silent remote, then late completion.
        remote_en  = 1'b0;
        forced_ack = 1'b0;
        base = done_cnt;
        send(124'h7777);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 9) chk("timeout_early", 128'(timeout_err), 128'(0));
            if (c == 13) begin
                chk("timeout_set", 128'(timeout_err), 128'(1));
                chk("timeout_req_held", 128'(bus.xfer_req), 128'(1));
            end
            next_cycle();
        end
        forced_ack = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.xfer_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_req_fell", 128'(bus.xfer_req), 128'(0));
        next_cycle();
        forced_ack = 1'b0;
        wait_dones(base + 1, 50);
        @(negedge clk);
        chk("timeout_sticky", 128'(timeout_err), 128'(1));
        chk("timeout_count", 128'(xfer_count), 128'(2));
        next_cycle();

        // Reset in the middle of REQ.
        send(124'h1234_5678);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("midreq_busy_before", 128'(busy), 128'(1));
        next_cycle();
        do_reset();
        @(negedge clk);
        chk("midreq_req", 128'(bus.xfer_req), 128'(0));
        chk("midreq_data", 128'(bus.xfer_data), 128'(0));
        chk("midreq_busy", 128'(busy), 128'(0));
        chk("midreq_count", 128'(xfer_count), 128'(0));
        chk("midreq_err", 128'(timeout_err), 128'(0));
        chk("midreq_ready", 128'(bus.in_ready), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx.md
Name: arf124b192e1r1w0cbbehcaa4acw_cdc_req_tx

Overview:
Transmit end of the four-phase req/ack level handshake used to move a register-file word into another clock domain. The receive end double-syncs xfer_req and returns xfer_ack.
This block accepts a word through a valid/ready port, holds it stable on xfer_data, and drives xfer_req. It synchronizes the returning ack itself and sequences all four phases. It also counts completed transfers and flags a stalled handshake.

Parameters:
DATA_W, 124, width of the transferred word.
SYNC_STAGES, 2, number of flops in the ack synchronizer. Legal values are 2 to 4.
TIMEOUT_CYC, 255, cycles to wait in REQ or REL before timeout_err is set. 0 disables the timeout.
CNT_W, 16, width of xfer_count.

Ports:
clk  in  1  single clock for the block.
rst  in  1  reset, synchronous and active-high.
in_valid  in  1  source word valid.
in_ready  out  1  block can accept a word this cycle.
in_data  in  DATA_W  source word.
xfer_req  out  1  request level to the remote domain; driven directly from a flop.
xfer_data  out  DATA_W  captured word; driven directly from flops.
xfer_ack  in  1  asynchronous ack level from the remote domain.
done  out  1  one-cycle pulse when a transfer completes.
busy  out  1  state is not IDLE.
timeout_err  out  1  sticky handshake-stall flag.
xfer_count  out  CNT_W  number of completed transfers; wraps.

Behaviour:
- Ack synchronizer:
  - SYNC_STAGES flops in series, all reset to 0.
  - ack_s is the last stage.
  - An xfer_ack edge is visible on ack_s SYNC_STAGES cycles after it is stable at the input.
- Reset: with rst=1 at a clock edge, all of the following apply.
  - state=IDLE.
  - xfer_req=0, xfer_data=0.
  - done=0, timeout_err=0, xfer_count=0.
  - Timeout counter=0, sync flops=0.
  - Reset mid-transfer aborts it immediately; the remote side sees req fall.
- in_ready = (state==IDLE) && !ack_s. A stale ack from the remote side blocks new accepts.
- State IDLE:
  - Accept occurs when in_valid && in_ready at edge N.
  - xfer_data <= in_data at that edge.
  - xfer_req=1 from cycle N+1; state -> REQ.
  - Handshake latency from accept to req is 1 cycle.
  - in_data is ignored when no accept occurs.
- State REQ:
  - xfer_req stays 1 and xfer_data is frozen.
  - When ack_s==1 is sampled: xfer_req=0 from the next cycle; state -> REL.
- State REL:
  - xfer_req stays 0 and xfer_data is still frozen.
  - When ack_s==0 is sampled, state -> IDLE on that edge. In the same cycle:
    - done=1 for exactly one cycle;
    - xfer_count increments modulo 2^CNT_W, so all-ones wraps to 0.
  - The next accept is possible in the cycle after done, because in_ready follows IDLE combinationally.
- Minimum transfer period is 2*SYNC_STAGES+2 cycles, assuming the remote echo is instant.
- Timeout:
  - The counter resets to 0 on every state change.
  - It increments each cycle in REQ or REL and saturates at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC (when nonzero) sets timeout_err.
  - timeout_err clears only on rst.
  - The FSM keeps waiting and never abandons a phase, to preserve protocol integrity.
- busy=1 in REQ and REL.
- done and in_ready are never both 1 together with an accept in the same cycle as a REL exit.
- xfer_data changes only on an accept edge.

Test Plan:
- Single transfer, SYNC_STAGES=2:
  - Stimulus: accept in_data=0x0ABC at cycle 0; a model remote sets xfer_ack=1 one cycle after it sees req=1 and clears it one cycle after req=0.
  - Required: req rises at cycle 1 and falls at cycle 5; done at cycle 8; xfer_count=1; xfer_data=0x0ABC from cycle 1 through cycle 8.
- Back-to-back:
  - Stimulus: in_valid held high with words 1, 2, 3.
  - Required: each word is captured only in IDLE; exactly 3 done pulses; xfer_count=3; no xfer_data change while busy.
- Stale ack:
  - Stimulus: xfer_ack=1 while idle.
  - Required: in_ready=0 from cycle 2 until 2 cycles after ack falls; no accept occurs.
- Timeout:
  - Stimulus: TIMEOUT_CYC=10 and a remote that never acks.
  - Required: timeout_err=1 after 10 cycles in REQ; req stays 1. A later ack completes the transfer normally with done=1, and timeout_err stays 1.
- Reset mid-REQ:
  - Stimulus: assert rst for 1 cycle.
  - Required: the next cycle shows req=0, xfer_data=0, busy=0, count=0, timeout_err=0, in_ready=1 (with ack low).
- Count wrap:
  - Stimulus: CNT_W=2 and 5 transfers.
  - Required: xfer_count sequence 1, 2, 3, 0, 1.
